twiddle_table_gen: RTL

Sequential twiddle-factor table generator for the NTT datapath. Accepts a root of unity `omega` and modulus `mod`, and computes `omega^k mod mod` for k = 0..N-1 iteratively with one modular multiply per cycle. Results go into an internal table, which the butterfly stages read through a registered read port. It is the parametrised successor of the fixed 8-entry, 8-bit combinational power generator: width and depth are generic, and it adds a start/done handshake, a validity flag and a modulus-error flag.

---
 rtl/ntt_pkg.sv | 23 ++
 rtl/twiddle_table_gen_if.sv | 27 ++
 rtl/mod_mult.sv | 15 +
 rtl/twiddle_table_gen.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT constants, twiddle FSM state type and bit-reverse helper
package ntt_pkg;

   localparam int NTT_W = 8;
   localparam int NTT_N = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GEN  = 2'd1,
      ST_DONE = 2'd2
   } twgen_state_t;

   // Reverse the low aw bits of k; bits above aw come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] k, input int aw);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < aw; i++) begin
         r[i] = k[aw-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/twiddle_table_gen_if.sv
// rtl/twiddle_table_gen_if.sv - control, flag and read-port bundle of the twiddle generator
interface twiddle_table_gen_if
   import ntt_pkg::*;
#(
   parameter int W  = NTT_W,
   parameter int AW = $clog2(NTT_N)
);
   logic          start;
   logic [W-1:0]  omega;
   logic [W-1:0]  mod;
   logic          busy;
   logic          done;
   logic          table_valid;
   logic          mod_err;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_data;

   modport master (
      output start, omega, mod, rd_addr,
      input  busy, done, table_valid, mod_err, rd_data
   );

   modport slave (
      input  start, omega, mod, rd_addr,
      output busy, done, table_valid, mod_err, rd_data
   );
endinterface

// File: rtl/mod_mult.sv
// rtl/mod_mult.sv - combinational (a * b) % m over the full 2W-bit product
module mod_mult #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] m,
   output logic [W-1:0] r
);
   logic [2*W-1:0] prod;

   assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
   // m == 0 never reaches a running generation; return 0 rather than an undefined divide
   assign r = (m == '0) ? '0 : W'(prod % {{W{1'b0}}, m});
endmodule

// File: rtl/twiddle_table_gen.sv
// rtl/twiddle_table_gen.sv - iterative omega^k mod m table builder; TWIDDLE_BITREV_EN selects bit-reversed storage
module twiddle_table_gen
   import ntt_pkg::*;
#(
   parameter int W = NTT_W,
   parameter int N = NTT_N
) (
   input logic                clk,
   input logic                rst_n,
   twiddle_table_gen_if.slave bus
);
   localparam int AW = $clog2(N);

   twgen_state_t  state, state_nx;
   logic [W-1:0]  omega_l, mod_l;
   logic [W-1:0]  acc, acc_nx;
   logic [AW-1:0] k, wr_addr;
   logic [W-1:0]  tbl [N];
   logic          accept, reject, wr_en, last;
   logic          busy_q, done_q, valid_q, err_q;
   logic [W-1:0]  rd_q;

   assign last = (k == AW'(N - 1));

`ifdef TWIDDLE_BITREV_EN
   assign wr_addr = AW'(bitrev(32'(k), AW));
`else
   assign wr_addr = k;
`endif

   mod_mult #(.W(W)) u_mod_mult (
      .a (acc),
      .b (omega_l),
      .m (mod_l),
      .r (acc_nx)
   );

   // next-state and per-cycle control decode
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      reject   = 1'b0;
      wr_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.mod != '0) begin
                  accept   = 1'b1;
                  state_nx = ST_GEN;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         ST_GEN: begin
            wr_en = 1'b1;
            if (last) state_nx = ST_DONE;
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // operand latch, power accumulator, index counter and registered flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         omega_l <= '0;
         mod_l   <= '0;
         acc     <= '0;
         k       <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // flags lag the FSM by one edge so they line up with the table writes
         busy_q <= wr_en;
         done_q <= (state == ST_DONE);
         if (accept) begin
            omega_l <= bus.omega;
            mod_l   <= bus.mod;
            acc     <= (bus.mod == W'(1)) ? '0 : W'(1);
            k       <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
         end else if (reject) begin
            valid_q <= 1'b0;
            err_q   <= 1'b1;
         end else if (wr_en) begin
            acc <= acc_nx;
            k   <= k + 1'b1;
         end else if (state == ST_DONE) begin
            valid_q <= 1'b1;
         end
      end
   end

   // table storage; contents are only meaningful while table_valid is set
   always_ff @(posedge clk) begin
      if (wr_en) tbl[wr_addr] <= acc;
   end

   // registered read port, independent of the generator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= tbl[bus.rd_addr];
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.table_valid = valid_q;
   assign bus.mod_err     = err_q;
   assign bus.rd_data     = rd_q;
endmodule
